// File: rtl/enc_pkg.sv
// Shared types and the word transform used by the enc pipeline stages.
// The transform works on a fixed wide vector so one function serves every DATA_W up to ENC_MAX_W.
package enc_pkg;

   typedef enum logic [1:0] {
      ENC_BYPASS   = 2'b00,
      ENC_XOR      = 2'b01,
      ENC_ROTL_XOR = 2'b10,
      ENC_XOR_ROTR = 2'b11
   } enc_mode_t;

   localparam int unsigned ENC_MAX_W = 64;
   localparam logic [ENC_MAX_W-1:0] ENC_MASK_DEFAULT = {(ENC_MAX_W/2){2'b10}};

   function automatic logic [ENC_MAX_W-1:0] enc_width_keep(input int unsigned width);
      logic [ENC_MAX_W-1:0] keep;
      if (width >= ENC_MAX_W) begin
         keep = {ENC_MAX_W{1'b1}};
      end else begin
         keep = (ENC_MAX_W'(1) << width) - ENC_MAX_W'(1);
      end
      return keep;
   endfunction

   // Rotates are confined to the low 'width' bits; bits above are forced to zero.
   function automatic logic [ENC_MAX_W-1:0] enc_rotl(
      input logic [ENC_MAX_W-1:0] value,
      input int unsigned          rot,
      input int unsigned          width
   );
      logic [ENC_MAX_W-1:0] keep;
      logic [ENC_MAX_W-1:0] v;
      keep = enc_width_keep(width);
      v    = value & keep;
      return ((v << rot) | (v >> (width - rot))) & keep;
   endfunction

   function automatic logic [ENC_MAX_W-1:0] enc_rotr(
      input logic [ENC_MAX_W-1:0] value,
      input int unsigned          rot,
      input int unsigned          width
   );
      logic [ENC_MAX_W-1:0] keep;
      logic [ENC_MAX_W-1:0] v;
      keep = enc_width_keep(width);
      v    = value & keep;
      return ((v >> rot) | (v << (width - rot))) & keep;
   endfunction

   function automatic logic [ENC_MAX_W-1:0] enc_apply(
      input logic [ENC_MAX_W-1:0] data,
      input logic [ENC_MAX_W-1:0] mask,
      input enc_mode_t            mode,
      input int unsigned          rot,
      input int unsigned          width
   );
      logic [ENC_MAX_W-1:0] keep;
      logic [ENC_MAX_W-1:0] result;
      keep = enc_width_keep(width);
      case (mode)
         ENC_BYPASS:   result = data & keep;
         ENC_XOR:      result = (data ^ mask) & keep;
         ENC_ROTL_XOR: result = (enc_rotl(data, rot, width) ^ mask) & keep;
         ENC_XOR_ROTR: result = enc_rotr(data ^ mask, rot, width);
         default:      result = data & keep;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// Two-entry skid buffer with a registered s_ready; the output register holds the head word.
// Generic over DATA_W so the earlier enc stages can reuse it unchanged.
module enc_skid_buf #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              ready_q, ready_d;
   logic              accept;
   logic              deliver;

   assign accept  = s_valid & ready_q;
   assign deliver = out_valid_q & m_ready;

   // A full skid entry holds ready low, so a deliver that drains the skid never coincides with an accept.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (deliver) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_data_d = s_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = s_data;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
         end
      end
      ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign s_ready = ready_q;
   assign m_valid = out_valid_q;
   assign m_data  = out_data_q;

endmodule

// File: rtl/enc_mask_stage.sv
// Final enc pipeline stage: runtime-loadable XOR mask with optional rotate, skid-buffered
// handshake and a wrap-around count of delivered words.
module enc_mask_stage
   import enc_pkg::*;
#(
   parameter int unsigned          DATA_W   = 16,
   parameter logic [DATA_W-1:0]    MASK_RST = DATA_W'(ENC_MASK_DEFAULT),
   parameter int unsigned          ROT_AMT  = 3,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] mask_in,
   input  logic              mask_load,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  word_cnt
);

   logic [DATA_W-1:0] mask_q;
   logic [DATA_W-1:0] xf_data;
   logic [CNT_W-1:0]  cnt_q;
   logic              deliver;

   // The word is transformed before it enters the buffer, so later mode or mask changes cannot touch it.
   assign xf_data = DATA_W'(enc_apply(ENC_MAX_W'(s_data), ENC_MAX_W'(mask_q),
                                      enc_mode_t'(mode), ROT_AMT, DATA_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= MASK_RST;
      end else if (mask_load) begin
         mask_q <= mask_in;
      end
   end

   enc_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (xf_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data)
   );

   assign deliver = m_valid & m_ready;

   // Clear takes priority over a same-cycle deliver.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (deliver) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign word_cnt = cnt_q;

endmodule

// File: tb/tb_enc_mask_stage.sv
// Directed self-checking bench for enc_mask_stage (DATA_W=16, ROT_AMT=3, CNT_W=4).
module tb_enc_mask_stage;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic [1:0]  mode;
   logic [15:0] mask_in;
   logic        mask_load;
   logic        cnt_clr;
   logic [3:0]  word_cnt;

   int checks;
   int errors;

   enc_mask_stage #(
      .DATA_W  (16),
      .ROT_AMT (3),
      .CNT_W   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .mode      (mode),
      .mask_in   (mask_in),
      .mask_load (mask_load),
      .cnt_clr   (cnt_clr),
      .word_cnt  (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      mode = 2'b00; mask_in = '0; mask_load = 1'b0; cnt_clr = 1'b0;
      tick();
      tick();
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready got=%b exp=0", s_ready); end
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++;
      if (m_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_m_data got=%h exp=0000", m_data); end
      rst = 1'b0;
      tick();
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_s_ready got=%b exp=1", s_ready); end
      checks++;
      if (word_cnt !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_cnt got=%0d exp=0", word_cnt); end
   endtask

   task automatic test_xor();
      mode = 2'b01; s_data = 16'h1234; s_valid = 1'b1; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'hB89E)
         begin errors++; $display("[TB] FAIL xor_data got=%b/%h exp=1/b89e", m_valid, m_data); end
      tick();
      checks++;
      if (word_cnt !== 4'd1) begin errors++; $display("[TB] FAIL xor_cnt got=%0d exp=1", word_cnt); end
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL xor_drain got=%b exp=0", m_valid); end
   endtask

   task automatic test_rotate();
      mode = 2'b10; s_data = 16'h8001; s_valid = 1'b1; m_ready = 1'b1;
      tick();
      checks++;
      if (m_data !== 16'hAAA6) begin errors++; $display("[TB] FAIL rotl_xor got=%h exp=aaa6", m_data); end
      mode = 2'b11; s_data = 16'hAAA6;
      tick();
      s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h8001)
         begin errors++; $display("[TB] FAIL xor_rotr got=%b/%h exp=1/8001", m_valid, m_data); end
      tick();
      checks++;
      if (word_cnt !== 4'd3) begin errors++; $display("[TB] FAIL rotate_cnt got=%0d exp=3", word_cnt); end
   endtask

   task automatic test_backpressure();
      logic [15:0] got [8];
      int          n_got;
      logic        acc;
      mode = 2'b00; m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0001;
      for (int i = 0; i < 8; i++) begin
         acc = s_valid & s_ready;
         tick();
         if (acc) begin
            if (s_data == 16'h0004) s_valid = 1'b0;
            else s_data = s_data + 16'h0001;
         end
      end
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_ready got=%b exp=0", s_ready); end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0001)
         begin errors++; $display("[TB] FAIL bp_hold got=%b/%h exp=1/0001", m_valid, m_data); end
      checks++;
      if (s_data !== 16'h0003) begin errors++; $display("[TB] FAIL bp_accepted next=%h exp=0003", s_data); end
      m_ready = 1'b1;
      n_got = 0;
      for (int i = 0; i < 12; i++) begin
         if (m_valid) begin
            if (n_got < 8) got[n_got] = m_data;
            n_got++;
         end
         acc = s_valid & s_ready;
         tick();
         if (acc) begin
            if (s_data == 16'h0004) s_valid = 1'b0;
            else s_data = s_data + 16'h0001;
         end
      end
      s_valid = 1'b0;
      checks++;
      if (n_got !== 4) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=4", n_got); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i < n_got && got[i] !== 16'(i + 1))
            begin errors++; $display("[TB] FAIL bp_order[%0d] got=%h exp=%h", i, got[i], 16'(i + 1)); end
      end
      checks++;
      if (word_cnt !== 4'd7) begin errors++; $display("[TB] FAIL bp_cnt got=%0d exp=7", word_cnt); end
   endtask

   task automatic test_mask_load();
      mode = 2'b01; m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h00FF;
      mask_in = 16'h0F0F; mask_load = 1'b1;
      tick();
      mask_load = 1'b0;
      checks++;
      if (m_data !== 16'hAA55) begin errors++; $display("[TB] FAIL mask_old got=%h exp=aa55", m_data); end
      tick();
      s_valid = 1'b0;
      checks++;
      if (m_data !== 16'h0FF0) begin errors++; $display("[TB] FAIL mask_new got=%h exp=0ff0", m_data); end
      tick();
   endtask

   task automatic test_counter();
      m_ready = 1'b1; mode = 2'b00; s_data = 16'h0055;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checks++;
      if (word_cnt !== 4'd0) begin errors++; $display("[TB] FAIL cnt_clear got=%0d exp=0", word_cnt); end
      s_valid = 1'b1;
      repeat (15) tick();
      s_valid = 1'b0;
      tick();
      checks++;
      if (word_cnt !== 4'd15) begin errors++; $display("[TB] FAIL cnt_15 got=%0d exp=15", word_cnt); end
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      tick();
      checks++;
      if (word_cnt !== 4'd0) begin errors++; $display("[TB] FAIL cnt_wrap got=%0d exp=0", word_cnt); end
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checks++;
      if (word_cnt !== 4'd0 || m_valid !== 1'b0)
         begin errors++; $display("[TB] FAIL cnt_clr_wins got=%0d/%b exp=0/0", word_cnt, m_valid); end
   endtask

   task automatic test_reset_mid();
      mode = 2'b01; mask_in = 16'h1111; mask_load = 1'b1; m_ready = 1'b0;
      s_valid = 1'b1; s_data = 16'h0101;
      tick();
      mask_load = 1'b0;
      tick();
      s_valid = 1'b0;
      rst = 1'b1; m_ready = 1'b1;
      tick();
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || word_cnt !== 4'd0)
         begin errors++; $display("[TB] FAIL midrst got=%b/%b/%0d exp=0/0/0", m_valid, s_ready, word_cnt); end
      rst = 1'b0;
      tick();
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0)
         begin errors++; $display("[TB] FAIL midrst_release got=%b/%b exp=1/0", s_ready, m_valid); end
      s_valid = 1'b1; s_data = 16'h0000;
      tick();
      s_valid = 1'b0;
      checks++;
      if (m_data !== 16'hAAAA) begin errors++; $display("[TB] FAIL midrst_mask got=%h exp=aaaa", m_data); end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_xor();
      test_rotate();
      test_backpressure();
      test_mask_load();
      test_counter();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/enc_mask_stage.md
Name: enc_mask_stage

Overview:
Parametrised successor to the fixed 16-bit XOR cleanup stage. It is the final transform stage of the encryption pipeline, placed after the round stages and before the output formatter. It applies a runtime-loadable XOR mask, with optional rotate, under a full valid/ready handshake. A two-entry skid buffer provides full throughput with a registered s_ready. It also keeps a wrap-around count of delivered words.

Parameters:
DATA_W, 16, data path width in bits (must be at least 2).
MASK_RST, {DATA_W/2{2'b10}}, mask register reset value (0xAAAA at 16 bits).
ROT_AMT, 3, rotate amount used by the rotate modes (0 < ROT_AMT < DATA_W).
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  in  1  clock; all registers update on the rising edge
rst  in  1  reset, synchronous, active-high
s_valid  in  1  upstream word valid
s_ready  out  1  stage can accept a word (registered)
s_data  in  DATA_W  upstream word
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  DATA_W  transformed word
mode  in  2  transform select, sampled per accepted word
mask_in  in  DATA_W  new mask value
mask_load  in  1  load mask_in into the mask register
cnt_clr  in  1  clear word_cnt
word_cnt  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset is synchronous, active-high, on clk; there is a single clock domain.
- Reset values: s_ready=0, m_valid=0, m_data=0, word_cnt=0, mask=MASK_RST, skid entry empty.
- s_ready rises the first cycle after rst deasserts.
- Accept event: s_valid && s_ready. Deliver event: m_valid && m_ready.
- Transform is computed at accept from the current mode and the current mask register:
  - 00: bypass, d.
  - 01: d ^ mask.
  - 10: rotl(d, ROT_AMT) ^ mask.
  - 11: rotr(d ^ mask, ROT_AMT), the inverse of mode 10.
- Latency: an accepted word appears on m_data the next cycle when the output register is empty or being delivered that cycle.
- Skid buffer:
  - The output register holds the head word; the skid register holds at most one more.
  - If a word is accepted while the output register is occupied and not delivered that cycle, the word goes to the skid register.
  - s_ready(next) = !skid_full(next).
  - On deliver with the skid register full, the skid word moves to the output register. A same-cycle accept then cannot occur, because s_ready is already 0.
- Sustained s_valid=1 and m_ready=1 gives one word per cycle with no bubbles.
- m_valid and m_data hold stable while m_valid && !m_ready. Ordering is strictly FIFO.
- Mask load:
  - mask_load writes mask_in at the clock edge.
  - A word accepted in the same cycle uses the old mask; the new mask applies from the next accept.
  - Words already buffered are not re-masked.
- Counter:
  - word_cnt increments on every deliver and wraps from 2^CNT_W-1 to 0.
  - cnt_clr forces word_cnt to 0 and wins over a same-cycle deliver (result 0).
- Reset mid-stream: rst asserted for any cycle discards buffered words and restores all reset values. No word is delivered during rst.
- Mode or mask changes while words are buffered do not alter those words.

Decomposition:
- Package enc_pkg:
  - enc_mode_t enum: ENC_BYPASS=2'b00, ENC_XOR=2'b01, ENC_ROTL_XOR=2'b10, ENC_XOR_ROTR=2'b11.
  - ENC_MASK_DEFAULT constant.
  - Transform function enc_apply(data, mask, mode, rot).
- Sub-module enc_skid_buf: a generic DATA_W two-entry skid buffer with a registered ready, reusable across the earlier enc stages.
- The top level holds the mask register, the transform and the counter.

Test Plan:
- Reset then idle: hold rst 2 cycles -> s_ready=0 and m_valid=0 during rst; s_ready=1 the cycle after; word_cnt=0.
- Mode 01, default mask, DATA_W=16: send 0x1234 with m_ready=1 -> m_data=0xB89E one cycle later; word_cnt=1.
- Mode 10, then mode 11 with ROT_AMT=3, mask 0xAAAA: send 0x8001 -> mode 10 gives 0x000C^0xAAAA=0xAAA6; feeding 0xAAA6 with mode 11 returns 0x8001.
- Backpressure: stream 0x0001..0x0004 (mode 00) with m_ready=0 -> two words buffered, s_ready=0, m_data holds 0x0001. Then release m_ready -> order 1,2,3,4, no loss or duplication.
- Mask load collision: accept 0x00FF with mask_load=1, mask_in=0x0F0F in the same cycle (mode 01) -> output 0xAA55. The next word 0x00FF -> 0x0FF0.
- Counter edge, CNT_W=4: 15 delivers -> word_cnt=15; 16th -> 0; cnt_clr in the same cycle as a deliver -> 0.
